// File: rtl/load_bin.sv
// ---------------------------------------------------------------------------
// load_bin
//   Responder side of the bin manager's load handshake. On a start pulse it
//   latches the requested bin number and copies that bin into the sat_engine
//   core's local storage:
//     - it reads the bin's NC clause words and writes each one to the core;
//     - it reads the bin's NV global variable ids from the var-map memory;
//     - for each id it reads {value, level} from the var-state memory and
//       writes it to the core.
//   Id 0 marks an empty slot. Such a slot gets no var-state read, and its
//   core write carries value 0 and level 0. When the last write is done,
//   the block pulses done for one cycle.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start_load_i         one-cycle start pulse (honoured in IDLE only)
//   request_bin_num_i    bin to load (bins numbered from 1; 0 = nothing)
//   done_load_o          one-cycle completion pulse
//   cmem_*               clause memory read port (1-cycle latency)
//   vmap_*               var-map memory read port (1-cycle latency)
//   vstate_*             var-state memory read port (1-cycle latency)
//   clause_*             core clause write port
//   var_*                core variable write port
//
// Handshake semantics: every *_rd_o and *_wr_o is a single-cycle strobe that
// is never back-pressured. Read data is taken exactly one cycle after its
// read strobe. Addresses, indices and data are driven as 0 whenever their
// strobe is low.
// ---------------------------------------------------------------------------
module load_bin #(
   parameter int WIDTH_BIN_ID  = 10,
   parameter int WIDTH_CIDX    = 3,
   parameter int WIDTH_VIDX    = 3,
   parameter int WIDTH_CLAUSES = 16,
   parameter int WIDTH_VAR     = 12,
   parameter int WIDTH_VAL     = 3,
   parameter int WIDTH_LVL     = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start_load_i,
   input  logic [WIDTH_BIN_ID-1:0]            request_bin_num_i,
   output logic                               done_load_o,
   output logic                               cmem_rd_o,
   output logic [WIDTH_BIN_ID+WIDTH_CIDX-1:0] cmem_addr_o,
   input  logic [WIDTH_CLAUSES-1:0]           cmem_rdata_i,
   output logic                               vmap_rd_o,
   output logic [WIDTH_BIN_ID+WIDTH_VIDX-1:0] vmap_addr_o,
   input  logic [WIDTH_VAR-1:0]               vmap_rdata_i,
   output logic                               vstate_rd_o,
   output logic [WIDTH_VAR-1:0]               vstate_addr_o,
   input  logic [WIDTH_VAL+WIDTH_LVL-1:0]     vstate_rdata_i,
   output logic                               clause_wr_o,
   output logic [WIDTH_CIDX-1:0]              clause_idx_o,
   output logic [WIDTH_CLAUSES-1:0]           clause_data_o,
   output logic                               var_wr_o,
   output logic [WIDTH_VIDX-1:0]              var_idx_o,
   output logic [WIDTH_VAL-1:0]               var_value_o,
   output logic [WIDTH_LVL-1:0]               var_lvl_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [WIDTH_BIN_ID-1:0] bin_q, bin_d;
   // phase_q: 0 while clause reads are issued, 1 while var-map reads are issued
   logic                    phase_q, phase_d;
   logic [WIDTH_CIDX-1:0]   cidx_q, cidx_d;
   logic [WIDTH_VIDX-1:0]   vidx_q, vidx_d;

   // Read-to-write pipeline bookkeeping
   logic                    cwr_q;        // clause data arrives this cycle
   logic [WIDTH_CIDX-1:0]   cwr_idx_q;
   logic                    vmap_vld_q;   // var id arrives this cycle
   logic [WIDTH_VIDX-1:0]   vmap_idx_q;
   logic                    vwr_q;        // var state arrives this cycle
   logic                    vzero_q;      // slot was empty (id 0)
   logic [WIDTH_VIDX-1:0]   vwr_idx_q;

   logic                    cmem_rd;
   logic                    vmap_rd;
   logic [WIDTH_BIN_ID-1:0] bin_m1;

   assign bin_m1 = bin_q - 1'b1;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         phase_q <= 1'b0;
         cidx_q  <= '0;
         vidx_q  <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         phase_q <= phase_d;
         cidx_q  <= cidx_d;
         vidx_q  <= vidx_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and read-issue logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      phase_d = phase_q;
      cidx_d  = cidx_q;
      vidx_d  = vidx_q;
      cmem_rd = 1'b0;
      vmap_rd = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_load_i) begin
               bin_d   = request_bin_num_i;
               phase_d = 1'b0;
               cidx_d  = '0;
               vidx_d  = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (bin_q == '0) begin
               // Bin 0 does not exist: finish without touching memory
               state_d = DONE;
            end else if (!phase_q) begin
               cmem_rd = 1'b1;
               cidx_d  = cidx_q + 1'b1;
               // The clause counter wraps here, so the var phase starts next cycle
               if (cidx_q == '1) phase_d = 1'b1;
            end else begin
               vmap_rd = 1'b1;
               vidx_d  = vidx_q + 1'b1;
               if (vidx_q == '1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Wait for the var-state pipeline to produce the last write
            if (vwr_q && (vwr_idx_q == '1)) state_d = DONE;
         end
         DONE: begin
            phase_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Read-data pipeline: each stage marks that its data arrives next cycle
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cwr_q      <= 1'b0;
         cwr_idx_q  <= '0;
         vmap_vld_q <= 1'b0;
         vmap_idx_q <= '0;
         vwr_q      <= 1'b0;
         vzero_q    <= 1'b0;
         vwr_idx_q  <= '0;
      end else begin
         cwr_q      <= cmem_rd;
         cwr_idx_q  <= cidx_q;
         vmap_vld_q <= vmap_rd;
         vmap_idx_q <= vidx_q;
         vwr_q      <= vmap_vld_q;
         vwr_idx_q  <= vmap_idx_q;
         vzero_q    <= vmap_vld_q && (vmap_rdata_i == '0);
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign done_load_o   = (state_q == DONE);

   assign cmem_rd_o     = cmem_rd;
   assign cmem_addr_o   = cmem_rd ? {bin_m1, cidx_q} : '0;

   assign vmap_rd_o     = vmap_rd;
   assign vmap_addr_o   = vmap_rd ? {bin_m1, vidx_q} : '0;

   // An empty slot (id 0) skips its var-state read
   assign vstate_rd_o   = vmap_vld_q && (vmap_rdata_i != '0);
   assign vstate_addr_o = vstate_rd_o ? vmap_rdata_i : '0;

   assign clause_wr_o   = cwr_q;
   assign clause_idx_o  = cwr_q ? cwr_idx_q : '0;
   assign clause_data_o = cwr_q ? cmem_rdata_i : '0;

   assign var_wr_o      = vwr_q;
   assign var_idx_o     = vwr_q ? vwr_idx_q : '0;
   assign {var_value_o, var_lvl_o} = (vwr_q && !vzero_q) ? vstate_rdata_i : '0;

endmodule
